ram1024x8_rr_arbiter: RTL
=========================

Name: ram1024x8_rr_arbiter

Overview:
- Shares one 1024x8 simple-dual-port RAM instance (independent write and read ports, unregistered read, 1-cycle synchronous read latency) between two requesters, A and B.
- Each requester issues single-beat read or write transactions with a req/gnt handshake.
- Write port and read port are arbitrated independently with round-robin priority, so one write and one read can complete in the same cycle.
- Sits between fabric logic and the RAM wrapper; drives all RAM control pins.

Parameters:
- ADDR_W, 10, address width; RAM depth = 2**ADDR_W.
- DATA_W, 8, data width.

Ports:
- Clk  input  1  single clock; also drives RAM WClk and RClk externally.
- Rst  input  1  synchronous, active-high reset.
- A_Req  input  1  requester A transaction request.
- A_Wr  input  1  1 = write, 0 = read; valid while A_Req.
- A_Addr  input  ADDR_W  A address.
- A_WD  input  DATA_W  A write data.
- A_Gnt  output  1  A request accepted this cycle.
- A_RVld  output  1  A read data valid.
- A_RD  output  DATA_W  A read data.
- B_Req, B_Wr, B_Addr, B_WD, B_Gnt, B_RVld, B_RD: same as A, for requester B.
- WA  output  ADDR_W  RAM write address.
- WD  output  DATA_W  RAM write data.
- WEN  output  1  RAM write enable.
- WClk_En  output  1  RAM write clock enable.
- RA  output  ADDR_W  RAM read address.
- RClk_En  output  1  RAM read clock enable.
- RD_In  input  DATA_W  RAM read data (RD pin).

Behaviour:
- Handshake:
  - Requester holds Req/Wr/Addr/WD stable until it sees Gnt.
  - Transfer occurs on the rising edge where Req & Gnt = 1.
  - Gnt is combinational from current Req/Wr and the priority registers.
  - Requester may drop Req without a grant; no transaction results.
- Write arbitration:
  - Candidates are requesters with Req & Wr.
  - One candidate: it is granted.
  - Two candidates: the one indicated by priority register wpri (0 = A, 1 = B) is granted.
  - After any write grant, wpri <= the non-granted requester.
- Read arbitration: identical, over requesters with Req & ~Wr, using priority register rpri.
- A requester gets at most one grant per cycle. A write by one requester and a read by the other are both granted in the same cycle.
- RAM drive (combinational):
  - WA/WD = granted writer's Addr/WD; WEN = WClk_En = 1 iff a write is granted.
  - RA = granted reader's Addr; RClk_En = 1 iff a read is granted.
  - When idle: WA = RA = 0, WD = 0, enables = 0.
- Read return:
  - Registered rowner and rpend capture the granted reader.
  - Exactly 1 cycle after the read grant edge, that requester's RVld = 1 for one cycle and its RD = RD_In. The other requester's RD holds 0.
  - Back-to-back reads by the same requester give RVld on consecutive cycles.
- Reset (Rst = 1 on an edge):
  - wpri = rpri = 0 (A favoured); rpend = 0; forwarding register cleared.
  - While Rst = 1: Gnt = 0, WEN = WClk_En = RClk_En = 0, RVld = 0, RD = 0.
  - Reset asserted with a read in flight: the pending RVld is dropped.
  - Reset mid-handshake: no grant is issued; the requester keeps Req and is served after reset.
- Address wrap: none; addresses are absolute, no range checking.

Optional Feature:
- Macro RAM_ARB_RAW_FWD_EN.
- Defined: when a write grant and a read grant occur in the same cycle with WA == RA, the arbiter registers WD. On the following RVld cycle, the reader's RD returns that registered value instead of RD_In, giving write-first semantics.
- Undefined: RD always equals RD_In. A same-address collision returns whatever the RAM drives; the value is unspecified and the bench must not check it. Adds no logic.

Test Plan:
- Reset then A write (addr 0x005, data 0xA5), then A read 0x005:
  - write cycle: A_Gnt = 1, WEN = 1, WA = 0x005;
  - one cycle after the read grant: A_RVld = 1, A_RD = 0xA5.
- A and B both write continuously for 4 cycles, from reset:
  - grants alternate A, B, A, B;
  - WA follows the granted requester's address.
- Same cycle, A writes 0x010 = 0x3C and B reads 0x020 (preloaded 0x77):
  - both Gnt = 1;
  - next cycle: B_RVld = 1, B_RD = 0x77, A_RVld = 0.
- Same cycle, A writes 0x030 = 0xE1 and B reads 0x030 (old 0x00):
  - with RAM_ARB_RAW_FWD_EN: B_RD = 0xE1;
  - without it: B_RVld = 1 only, value not checked.
- Read granted to A at edge N, Rst = 1 at edge N+1:
  - A_RVld stays 0;
  - wpri and rpri return to A.
- B alone reads three consecutive cycles (0x100, 0x101, 0x102 preloaded 0x11, 0x22, 0x33):
  - B_RVld = 1 for 3 consecutive cycles;
  - B_RD = 0x11, 0x22, 0x33.

Source files
------------

// File: rtl/ram1024x8_rr_arbiter_if.sv
// ram1024x8_rr_arbiter_if
// Bundles the two requester handshakes (A, B) and the RAM control pins
// that the arbiter drives toward a simple-dual-port RAM wrapper.
//   slave  : arbiter side (takes requests and RD_In, drives grants, read
//            returns and RAM pins)
//   master : fabric/RAM side (drives requests and RD_In)
// Signals:
//   A_/B_Req, _Wr, _Addr, _WD   request, 1=write/0=read, address, write data
//   A_/B_Gnt                    request accepted this cycle
//   A_/B_RVld, _RD              read data valid / read data
//   WA, WD, WEN, WClk_En        RAM write port
//   RA, RClk_En, RD_In          RAM read port
interface ram1024x8_rr_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              A_Req, A_Wr, A_Gnt, A_RVld;
  logic [ADDR_W-1:0] A_Addr;
  logic [DATA_W-1:0] A_WD, A_RD;
  logic              B_Req, B_Wr, B_Gnt, B_RVld;
  logic [ADDR_W-1:0] B_Addr;
  logic [DATA_W-1:0] B_WD, B_RD;
  logic [ADDR_W-1:0] WA, RA;
  logic [DATA_W-1:0] WD, RD_In;
  logic              WEN, WClk_En, RClk_En;

  modport slave (
    input  A_Req, A_Wr, A_Addr, A_WD, B_Req, B_Wr, B_Addr, B_WD, RD_In,
    output A_Gnt, A_RVld, A_RD, B_Gnt, B_RVld, B_RD,
    output WA, WD, WEN, WClk_En, RA, RClk_En
  );

  modport master (
    output A_Req, A_Wr, A_Addr, A_WD, B_Req, B_Wr, B_Addr, B_WD, RD_In,
    input  A_Gnt, A_RVld, A_RD, B_Gnt, B_RVld, B_RD,
    input  WA, WD, WEN, WClk_En, RA, RClk_En
  );
endinterface

// File: rtl/ram1024x8_rr_arbiter.sv
// ram1024x8_rr_arbiter
// Shares one simple-dual-port RAM between requesters A and B. The write
// port and read port are arbitrated independently, each round-robin, so a
// write by one requester and a read by the other complete in the same cycle.
// Read data returns one cycle after the read grant on the owner's RVld/RD.
// Ports:
//   Clk  : single clock (also clocks the RAM)
//   Rst  : synchronous active-high reset
//   bus  : ram1024x8_rr_arbiter_if.slave (requester handshakes + RAM pins)
// Optional: define RAM_ARB_RAW_FWD_EN for write-first behaviour when a
// write and a read to the same address are granted in the same cycle.
module ram1024x8_rr_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic Clk,
  input  logic Rst,
  ram1024x8_rr_arbiter_if.slave bus
);

  // priority registers: 0 = A favoured, 1 = B favoured
  logic wpri_q, wpri_d, rpri_q, rpri_d;
  // rowner: 0 = A, 1 = B
  logic rpend_q, rpend_d, rowner_q, rowner_d;

  logic a_wc, b_wc, a_rc, b_rc;
  logic wg_a, wg_b, rg_a, rg_b, wr_any, rd_any;
  logic [ADDR_W-1:0] wa_s, ra_s;
  logic [DATA_W-1:0] wd_s, rd_sel;
  logic a_rvld, b_rvld;

  always_comb begin
    // Rst gates the candidates so nothing is granted while in reset.
    a_wc   = ~Rst & bus.A_Req &  bus.A_Wr;
    b_wc   = ~Rst & bus.B_Req &  bus.B_Wr;
    a_rc   = ~Rst & bus.A_Req & ~bus.A_Wr;
    b_rc   = ~Rst & bus.B_Req & ~bus.B_Wr;
    wg_a   = a_wc & (~b_wc | ~wpri_q);
    wg_b   = b_wc & (~a_wc |  wpri_q);
    rg_a   = a_rc & (~b_rc | ~rpri_q);
    rg_b   = b_rc & (~a_rc |  rpri_q);
    wr_any = wg_a | wg_b;
    rd_any = rg_a | rg_b;
    wa_s   = wg_a ? bus.A_Addr : (wg_b ? bus.B_Addr : '0);
    wd_s   = wg_a ? bus.A_WD   : (wg_b ? bus.B_WD   : '0);
    ra_s   = rg_a ? bus.A_Addr : (rg_b ? bus.B_Addr : '0);
  end

  always_comb begin
    wpri_d   = wpri_q;
    rpri_d   = rpri_q;
    // after a grant the loser (or the idle side) becomes favoured
    if (wr_any) wpri_d = wg_a;
    if (rd_any) rpri_d = rg_a;
    rpend_d  = rd_any;
    rowner_d = rd_any ? rg_b : rowner_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wpri_q   <= 1'b0;
      rpri_q   <= 1'b0;
      rpend_q  <= 1'b0;
      rowner_q <= 1'b0;
    end else begin
      wpri_q   <= wpri_d;
      rpri_q   <= rpri_d;
      rpend_q  <= rpend_d;
      rowner_q <= rowner_d;
    end
  end

`ifdef RAM_ARB_RAW_FWD_EN
  logic              fwd_vld_q, fwd_vld_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  always_comb begin
    fwd_vld_d  = wr_any & rd_any & (wa_s == ra_s);
    fwd_data_d = fwd_vld_d ? wd_s : fwd_data_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fwd_vld_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_vld_q  <= fwd_vld_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // the RAM returns old data on a same-cycle collision; substitute the new
  assign rd_sel = fwd_vld_q ? fwd_data_q : bus.RD_In;
`else
  assign rd_sel = bus.RD_In;
`endif

  assign a_rvld = ~Rst & rpend_q & ~rowner_q;
  assign b_rvld = ~Rst & rpend_q &  rowner_q;

  assign bus.A_Gnt   = wg_a | rg_a;
  assign bus.B_Gnt   = wg_b | rg_b;
  assign bus.A_RVld  = a_rvld;
  assign bus.B_RVld  = b_rvld;
  assign bus.A_RD    = a_rvld ? rd_sel : '0;
  assign bus.B_RD    = b_rvld ? rd_sel : '0;
  assign bus.WA      = wa_s;
  assign bus.WD      = wd_s;
  assign bus.WEN     = wr_any;
  assign bus.WClk_En = wr_any;
  assign bus.RA      = ra_s;
  assign bus.RClk_En = rd_any;

endmodule
